t07_mem_responder: RTL and testbench

Memory-side responder for the CPU's external memory port: it accepts the read/write/idle request that the core drives, stalls the core with `busy_o` for a fixed number of wait states, and then completes the access against an internal word-addressed store. It stands in for MMIO/instruction memory in simulation and in the standalone team build. Instruction fetch and data accesses share the single port.

---
 rtl/t07_mem_responder_if.sv | 27 ++
 rtl/t07_mem_responder.sv | 128 ++++++++++++
 tb/tb_t07_mem_responder.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t07_mem_responder_if.sv
// Single-port memory bus between the core (master) and the memory responder (slave).
interface t07_mem_responder_if;
    logic [1:0]  rwi_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        busy_o;
    logic        err_o;

    modport master (
        output rwi_i,
        output addr_i,
        output wdata_i,
        input  rdata_o,
        input  busy_o,
        input  err_o
    );

    modport slave (
        input  rwi_i,
        input  addr_i,
        input  wdata_i,
        output rdata_o,
        output busy_o,
        output err_o
    );
endinterface

// File: rtl/t07_mem_responder.sv
// Memory-side responder: captures a read/write request, stalls the core for LATENCY
// cycles, then completes the access against an internal word store.
module t07_mem_responder #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic                 clk,
    input logic                 nrst,
    t07_mem_responder_if.slave  bus
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [32:0]      SPAN     = 33'(4 * DEPTH);
    localparam logic [31:0]      OOR_DATA = 32'hDEAD_BEEF;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               wr_q,    wr_d;
    logic               oor_q,   oor_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q,   err_d;
    logic               mem_we;

    logic [31:0]        mem [DEPTH];

    logic [31:0]        addr_w;
    logic [31:0]        offset;
    logic               in_range;
    logic [IDX_W-1:0]   idx_req;
    logic [31:0]        rd_word;
    logic               unused_addr_lo;

    // Byte-lane bits never take part in decoding.
    assign addr_w         = {bus.addr_i[31:2], 2'b00};
    assign unused_addr_lo = ^bus.addr_i[1:0];
    assign offset         = addr_w - BASE_ADDR;
    assign in_range       = (addr_w >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    assign idx_req        = offset[IDX_W+1:2];
    assign rd_word        = mem[idx_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        oor_d   = oor_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                case (bus.rwi_i)
                    2'b01, 2'b10: begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                        wr_d    = bus.rwi_i[1];
                        oor_d   = !in_range;
                        idx_d   = idx_req;
                        wdata_d = bus.wdata_i;
                    end
                    2'b11:   err_d = 1'b1;
                    default: ;
                endcase
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_IDLE;
                    // Out-of-range accesses still run the full wait so the core never hangs.
                    if (oor_q) begin
                        err_d = 1'b1;
                        if (!wr_q) rdata_d = OOR_DATA;
                    end else if (wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = rd_word;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            oor_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            oor_q   <= oor_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Store is deliberately unreset; a reset during WAIT forces IDLE, so no write escapes.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= wdata_q;
    end

    assign bus.busy_o  = (state_q == S_WAIT);
    assign bus.rdata_o = rdata_q;
    assign bus.err_o   = err_q;

endmodule

// File: tb/tb_t07_mem_responder.sv
// Bench for t07_mem_responder: three instances (LATENCY 2, 1 and 5 with offset base)
// driven through a shared request bus gated by sel, checked against a word-store model.
module tb_t07_mem_responder;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    int          sel = 0;
    logic [1:0]  rwi = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;

    logic        obs_busy, obs_err;
    logic [31:0] obs_rdata;

    int total = 0;
    int bad   = 0;

    int          lat_c  [3] = '{2, 1, 5};
    int          dep_c  [3] = '{256, 16, 16};
    logic [31:0] base_c [3] = '{32'h0, 32'h0, 32'h1000};

    logic [31:0] mdl [int];
    logic [31:0] last_rd [3] = '{32'h0, 32'h0, 32'h0};

    typedef struct { int s; logic [31:0] a; } wr_rec_t;
    wr_rec_t written [$];

    always #5 clk = ~clk;

    t07_mem_responder_if if0 ();
    t07_mem_responder_if if1 ();
    t07_mem_responder_if if2 ();

    assign if0.rwi_i   = (sel == 0) ? rwi : 2'b00;
    assign if1.rwi_i   = (sel == 1) ? rwi : 2'b00;
    assign if2.rwi_i   = (sel == 2) ? rwi : 2'b00;
    assign if0.addr_i  = addr;
    assign if1.addr_i  = addr;
    assign if2.addr_i  = addr;
    assign if0.wdata_i = wdata;
    assign if1.wdata_i = wdata;
    assign if2.wdata_i = wdata;

    t07_mem_responder #(.DEPTH(256), .LATENCY(2), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .nrst(nrst), .bus(if0));
    t07_mem_responder #(.DEPTH(16), .LATENCY(1), .BASE_ADDR(32'h0)) dut1 (
        .clk(clk), .nrst(nrst), .bus(if1));
    t07_mem_responder #(.DEPTH(16), .LATENCY(5), .BASE_ADDR(32'h1000)) dut2 (
        .clk(clk), .nrst(nrst), .bus(if2));

    always_comb begin
        case (sel)
            1:       begin obs_busy = if1.busy_o; obs_err = if1.err_o; obs_rdata = if1.rdata_o; end
            2:       begin obs_busy = if2.busy_o; obs_err = if2.err_o; obs_rdata = if2.rdata_o; end
            default: begin obs_busy = if0.busy_o; obs_err = if0.err_o; obs_rdata = if0.rdata_o; end
        endcase
    end

    function automatic bit in_rng(input int s, input logic [31:0] a);
        logic [31:0] aw;
        aw = a & ~32'h3;
        return (aw >= base_c[s]) && ((aw - base_c[s]) < 32'(4 * dep_c[s]));
    endfunction

    function automatic int key(input int s, input logic [31:0] a);
        return s * 4096 + int'(((a & ~32'h3) - base_c[s]) >> 2);
    endfunction

    // Drives one request, then counts busy and err cycles until busy drops (bounded).
    task automatic access(input int s, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] d, input bit scr,
                          output int bcnt, output int ecnt, output logic [31:0] rd);
        bcnt = 0;
        ecnt = 0;
        @(negedge clk);
        sel = s; rwi = op; addr = a; wdata = d;
        @(posedge clk);
        #1;
        if (scr) begin
            rwi = 2'($urandom_range(0, 3)); addr = $urandom; wdata = $urandom;
        end else begin
            rwi = 2'b00;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ecnt += int'(obs_err);
            if (!obs_busy) break;
            bcnt++;
            if (scr) begin
                rwi = 2'($urandom_range(0, 3)); addr = $urandom; wdata = $urandom;
            end
        end
        rwi = 2'b00;
        rd  = obs_rdata;
    endtask

    task automatic test_reset();
        int bc, ec;
        logic [31:0] rd;
        logic [31:0] d;
        d = 32'h5A5A_1234;
        @(negedge clk);
        sel = 0; rwi = 2'b10; addr = 32'h10; wdata = d;
        @(posedge clk);
        #1 rwi = 2'b00;
        @(negedge clk);
        nrst = 1'b0;
        #1;
        total++; if (if0.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", if0.busy_o); end
        total++; if (if0.rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", if0.rdata_o); end
        total++; if (if0.err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", if0.err_o); end
        @(negedge clk);
        nrst = 1'b1;
        last_rd = '{32'h0, 32'h0, 32'h0};
        access(0, 2'b01, 32'h10, 32'h0, 1'b0, bc, ec, rd);
        total++; if (bc !== 2) begin bad++; $display("FAIL reset_read_busy got=%0d want=2", bc); end
        total++; if (rd === d) begin bad++; $display("FAIL reset_abort got=%h want=not %h", rd, d); end
        last_rd[0] = rd;
    endtask

    task automatic test_write_read();
        int bc, ec;
        logic [31:0] rd;
        access(0, 2'b10, 32'h20, 32'hCAFE_F00D, 1'b0, bc, ec, rd);
        mdl[key(0, 32'h20)] = 32'hCAFE_F00D;
        total++; if (bc !== 2) begin bad++; $display("FAIL wr_busy got=%0d want=2", bc); end
        total++; if (rd !== last_rd[0]) begin bad++; $display("FAIL wr_rdata_hold got=%h want=%h", rd, last_rd[0]); end
        total++; if (ec !== 0) begin bad++; $display("FAIL wr_err got=%0d want=0", ec); end
        access(0, 2'b01, 32'h20, 32'h0, 1'b0, bc, ec, rd);
        total++; if (bc !== 2) begin bad++; $display("FAIL rd_busy got=%0d want=2", bc); end
        total++; if (rd !== 32'hCAFE_F00D) begin bad++; $display("FAIL rd_data got=%h want=cafef00d", rd); end
        last_rd[0] = rd;
    endtask

    task automatic test_back_to_back();
        int bc, ec;
        logic [31:0] rd;
        logic [31:0] exp_d;
        for (int i = 0; i < 3; i++) begin
            access(0, 2'b10, 32'(4 * i), 32'(i + 1), 1'b0, bc, ec, rd);
            mdl[key(0, 32'(4 * i))] = 32'(i + 1);
        end
        @(negedge clk);
        sel = 0; rwi = 2'b01; addr = 32'h0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            total++;
            if (obs_busy !== ((c % 3) != 2)) begin
                bad++; $display("FAIL b2b_busy cycle=%0d got=%b want=%b", c, obs_busy, (c % 3) != 2);
            end
            if ((c % 3) == 2) begin
                exp_d = mdl[key(0, 32'(4 * (c / 3)))];
                total++;
                if (obs_rdata !== exp_d) begin
                    bad++; $display("FAIL b2b_rdata n=%0d got=%h want=%h", c / 3, obs_rdata, exp_d);
                end
                addr = 32'(4 * (c / 3 + 1));
            end
        end
        rwi = 2'b00;
        last_rd[0] = obs_rdata;
    endtask

    task automatic test_wait_inputs();
        int bc, ec;
        logic [31:0] rd;
        access(0, 2'b10, 32'h44, 32'h1357_9BDF, 1'b1, bc, ec, rd);
        mdl[key(0, 32'h44)] = 32'h1357_9BDF;
        total++; if (rd !== last_rd[0]) begin bad++; $display("FAIL scr_wr_hold got=%h want=%h", rd, last_rd[0]); end
        access(0, 2'b01, 32'h44, 32'h0, 1'b1, bc, ec, rd);
        total++; if (bc !== 2) begin bad++; $display("FAIL scr_busy got=%0d want=2", bc); end
        total++; if (rd !== 32'h1357_9BDF) begin bad++; $display("FAIL scr_rd got=%h want=13579bdf", rd); end
        total++; if (ec !== 0) begin bad++; $display("FAIL scr_err got=%0d want=0", ec); end
        last_rd[0] = rd;
    endtask

    task automatic test_errors();
        int bc, ec;
        logic [31:0] rd;
        access(0, 2'b11, 32'h0, 32'h0, 1'b0, bc, ec, rd);
        total++; if (bc !== 0) begin bad++; $display("FAIL ill_busy got=%0d want=0", bc); end
        total++; if (ec !== 1) begin bad++; $display("FAIL ill_err got=%0d want=1", ec); end
        access(0, 2'b01, 32'h400, 32'h0, 1'b0, bc, ec, rd);
        total++; if (bc !== 2) begin bad++; $display("FAIL oor_rd_busy got=%0d want=2", bc); end
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL oor_rd_data got=%h want=deadbeef", rd); end
        total++; if (ec !== 1) begin bad++; $display("FAIL oor_rd_err got=%0d want=1", ec); end
        last_rd[0] = rd;
        access(0, 2'b10, 32'h400, 32'h1234_5678, 1'b0, bc, ec, rd);
        total++; if (ec !== 1) begin bad++; $display("FAIL oor_wr_err got=%0d want=1", ec); end
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL oor_wr_hold got=%h want=deadbeef", rd); end
        access(0, 2'b01, 32'h0, 32'h0, 1'b0, bc, ec, rd);
        total++; if (rd !== mdl[key(0, 32'h0)]) begin bad++; $display("FAIL oor_wr_store got=%h want=%h", rd, mdl[key(0, 32'h0)]); end
        last_rd[0] = rd;
    endtask

    task automatic test_latency1();
        int bc, ec;
        logic [31:0] rd;
        access(1, 2'b10, 32'h8, 32'h0BAD_F00D, 1'b0, bc, ec, rd);
        mdl[key(1, 32'h8)] = 32'h0BAD_F00D;
        total++; if (bc !== 1) begin bad++; $display("FAIL l1_wr_busy got=%0d want=1", bc); end
        access(1, 2'b01, 32'h8, 32'h0, 1'b0, bc, ec, rd);
        total++; if (bc !== 1) begin bad++; $display("FAIL l1_rd_busy got=%0d want=1", bc); end
        total++; if (rd !== 32'h0BAD_F00D) begin bad++; $display("FAIL l1_rd_data got=%h want=0badf00d", rd); end
        last_rd[1] = rd;
    endtask

    task automatic test_base_offset();
        int bc, ec;
        logic [31:0] rd;
        access(2, 2'b10, 32'h1000, 32'hA5A5_0001, 1'b0, bc, ec, rd);
        mdl[key(2, 32'h1000)] = 32'hA5A5_0001;
        total++; if (ec !== 0) begin bad++; $display("FAIL base_wr_err got=%0d want=0", ec); end
        access(2, 2'b01, 32'h1000, 32'h0, 1'b0, bc, ec, rd);
        total++; if (bc !== 5) begin bad++; $display("FAIL base_busy got=%0d want=5", bc); end
        total++; if (rd !== 32'hA5A5_0001) begin bad++; $display("FAIL base_rd got=%h want=a5a50001", rd); end
        access(2, 2'b01, 32'h0FFC, 32'h0, 1'b0, bc, ec, rd);
        total++; if (bc !== 5) begin bad++; $display("FAIL below_busy got=%0d want=5", bc); end
        total++; if (ec !== 1) begin bad++; $display("FAIL below_err got=%0d want=1", ec); end
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL below_rd got=%h want=deadbeef", rd); end
        last_rd[2] = rd;
    endtask

    task automatic test_random();
        int bc, ec, s, pick;
        logic [31:0] rd, a, d, exp_rd;
        bit oor;
        for (int n = 0; n < 60; n++) begin
            pick = int'($urandom_range(0, 9));
            if (written.size() == 0 || pick < 4) begin
                s = int'($urandom_range(0, 2));
                oor = ($urandom_range(0, 7) == 0);
                a = base_c[s] + (oor ? 32'(4 * dep_c[s]) : 32'(4 * $urandom_range(0, dep_c[s] - 1)))
                    + 32'($urandom_range(0, 3));
                d = $urandom;
                access(s, 2'b10, a, d, 1'b0, bc, ec, rd);
                if (in_rng(s, a)) begin
                    mdl[key(s, a)] = d;
                    written.push_back('{s, a});
                end
                total++;
                if (bc !== lat_c[s] || ec !== int'(!in_rng(s, a)) || rd !== last_rd[s]) begin
                    bad++; $display("FAIL rnd_wr s=%0d a=%h busy=%0d err=%0d rd=%h want busy=%0d err=%0d rd=%h",
                                    s, a, bc, ec, rd, lat_c[s], int'(!in_rng(s, a)), last_rd[s]);
                end
            end else if (pick == 9) begin
                s = int'($urandom_range(0, 2));
                access(s, 2'b11, $urandom, $urandom, 1'b0, bc, ec, rd);
                total++;
                if (bc !== 0 || ec !== 1 || rd !== last_rd[s]) begin
                    bad++; $display("FAIL rnd_ill s=%0d busy=%0d err=%0d rd=%h want busy=0 err=1 rd=%h",
                                    s, bc, ec, rd, last_rd[s]);
                end
            end else begin
                pick = int'($urandom_range(0, written.size() - 1));
                s = written[pick].s;
                a = written[pick].a;
                if ($urandom_range(0, 5) == 0) a = base_c[s] + 32'(4 * dep_c[s]) + 32'(4 * $urandom_range(0, 3));
                exp_rd = in_rng(s, a) ? mdl[key(s, a)] : 32'hDEAD_BEEF;
                access(s, 2'b01, a, $urandom, 1'b0, bc, ec, rd);
                total++;
                if (bc !== lat_c[s] || ec !== int'(!in_rng(s, a)) || rd !== exp_rd) begin
                    bad++; $display("FAIL rnd_rd s=%0d a=%h busy=%0d err=%0d rd=%h want busy=%0d err=%0d rd=%h",
                                    s, a, bc, ec, rd, lat_c[s], int'(!in_rng(s, a)), exp_rd);
                end
                last_rd[s] = exp_rd;
            end
        end
    endtask

    initial begin
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_wait_inputs();
        test_errors();
        test_latency1();
        test_base_offset();
        test_random();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
